// File: rtl/dbus_arbiter.sv
// ============================================================================
// Module   : dbus_arbiter
// Purpose  : Round-robin Wishbone dbus arbiter sharing one memory port between
//            NUM_CORES cores, with per-transaction ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CORES-1:0]    i_cyc,
   input  logic [NUM_CORES-1:0]    i_we,
   input  logic [NUM_CORES*32-1:0] i_adr,
   input  logic [NUM_CORES*32-1:0] i_dat,
   input  logic [NUM_CORES*4-1:0]  i_sel,
   output logic [NUM_CORES-1:0]    o_ack,
   output logic [31:0]             o_rdt,
   output logic                    o_mem_cyc,
   output logic                    o_mem_we,
   output logic [31:0]             o_mem_adr,
   output logic [31:0]             o_mem_dat,
   output logic [3:0]              o_mem_sel,
   input  logic                    i_mem_ack,
   input  logic [31:0]             i_mem_rdt,
   output logic [NUM_CORES-1:0]    o_grant,
   output logic                    o_err
);

   localparam int                 c_IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [7:0]         c_CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_CORES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_GUARD = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_IDX_W-1:0]   r_owner;
   logic [c_IDX_W-1:0]   r_last;
   logic [7:0]           r_cnt;
   logic                 r_err;
   logic                 r_mem_cyc;
   logic [NUM_CORES-1:0] r_grant;

   int                   w_idx;
   logic                 w_found;
   logic [c_IDX_W-1:0]   w_next;
   logic [NUM_CORES-1:0] w_next_oh;
   logic                 w_timeout;
   logic                 w_done;

   // Scan downward so the nearest requester above r_last is the final writer.
   always_comb begin
      w_idx   = 0;
      w_found = 1'b0;
      w_next  = '0;
      for (int i = NUM_CORES; i >= 1; i--) begin
         w_idx = (int'(r_last) + i) % NUM_CORES;
         if (i_cyc[c_IDX_W'(w_idx)]) begin
            w_next  = c_IDX_W'(w_idx);
            w_found = 1'b1;
         end
      end
      for (int k = 0; k < NUM_CORES; k++) begin
         w_next_oh[k] = (w_next == c_IDX_W'(k));
      end
   end

   always_comb begin
      o_mem_we  = i_we[0];
      o_mem_adr = i_adr[31:0];
      o_mem_dat = i_dat[31:0];
      o_mem_sel = i_sel[3:0];
      for (int k = 0; k < NUM_CORES; k++) begin
         if (r_owner == c_IDX_W'(k)) begin
            o_mem_we  = i_we[k];
            o_mem_adr = i_adr[32*k +: 32];
            o_mem_dat = i_dat[32*k +: 32];
            o_mem_sel = i_sel[4*k +: 4];
         end
      end
   end

   always_comb begin
      w_timeout = (r_state == S_BUSY) && (r_cnt == c_CNT_LAST) && !i_mem_ack;
      w_done    = (r_state == S_BUSY) && (i_mem_ack || w_timeout);
      o_rdt     = ((r_state == S_BUSY) && i_mem_ack) ? i_mem_rdt : 32'd0;
      for (int k = 0; k < NUM_CORES; k++) begin
         o_ack[k] = w_done && (r_owner == c_IDX_W'(k));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_owner   <= '0;
         r_last    <= c_LAST_RST;
         r_cnt     <= 8'd0;
         r_err     <= 1'b0;
         r_mem_cyc <= 1'b0;
         r_grant   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_owner   <= w_next;
                  r_last    <= w_next;
                  r_cnt     <= 8'd0;
                  r_grant   <= w_next_oh;
                  r_mem_cyc <= 1'b1;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_done) begin
                  r_grant   <= '0;
                  r_mem_cyc <= 1'b0;
                  r_state   <= S_GUARD;
                  if (w_timeout) begin
                     r_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            // Gives the acked core a cycle to drop its stale request.
            S_GUARD: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_mem_cyc = r_mem_cyc;
   assign o_grant   = r_grant;
   assign o_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// ============================================================================
// Module   : tb_dbus_arbiter
// Purpose  : Self-checking bench for dbus_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic            clk;
   logic            rst;
   logic [N-1:0]    i_cyc;
   logic [N-1:0]    i_we;
   logic [N*32-1:0] i_adr;
   logic [N*32-1:0] i_dat;
   logic [N*4-1:0]  i_sel;
   logic [N-1:0]    o_ack;
   logic [31:0]     o_rdt;
   logic            o_mem_cyc;
   logic            o_mem_we;
   logic [31:0]     o_mem_adr;
   logic [31:0]     o_mem_dat;
   logic [3:0]      o_mem_sel;
   logic            i_mem_ack;
   logic [31:0]     i_mem_rdt;
   logic [N-1:0]    o_grant;
   logic            o_err;

   dbus_arbiter #(.NUM_CORES(N), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_cyc     (i_cyc),
      .i_we      (i_we),
      .i_adr     (i_adr),
      .i_dat     (i_dat),
      .i_sel     (i_sel),
      .o_ack     (o_ack),
      .o_rdt     (o_rdt),
      .o_mem_cyc (o_mem_cyc),
      .o_mem_we  (o_mem_we),
      .o_mem_adr (o_mem_adr),
      .o_mem_dat (o_mem_dat),
      .o_mem_sel (o_mem_sel),
      .i_mem_ack (i_mem_ack),
      .i_mem_rdt (i_mem_rdt),
      .o_grant   (o_grant),
      .o_err     (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_last;
   logic        m_err;
   logic        m_we  [N];
   logic [31:0] m_adr [N];
   logic [31:0] m_dat [N];
   logic [3:0]  m_sel [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int k, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
      m_we[k]  = we;
      m_adr[k] = adr;
      m_dat[k] = dat;
      m_sel[k] = sel;
      i_we[k]  = we;
      i_adr[32*k +: 32] = adr;
      i_dat[32*k +: 32] = dat;
      i_sel[4*k +: 4]   = sel;
   endtask

   task automatic rand_core(input int k);
      set_core(k, 1'($urandom), $urandom, $urandom, 4'($urandom));
   endtask

   // Winner: first requester scanning upward from last+1, wrapping.
   function automatic int predict(input logic [N-1:0] req, input int last);
      logic [N-1:0] r;
      for (int i = 1; i <= N; i++) begin
         r = req >> ((last + i) % N);
         if (r[0]) return (last + i) % N;
      end
      return -1;
   endfunction

   // One full transaction: wait for grant, ack after 'delay' BUSY cycles
   // (0 = memory never acks), then the guard cycle.
   task automatic txn(input int delay, input logic [31:0] rdt, input bit rereq,
                      input int exp_wait, output int got);
      int           exp;
      int           w;
      logic [N-1:0] oh;
      exp = predict(i_cyc, m_last);
      oh  = N'(1) << exp;
      w   = 0;
      do begin
         @(posedge clk); #1;
         i_mem_ack = 1'($urandom);
         i_mem_rdt = $urandom;
         #1;
         w++;
         if (o_grant == '0) chk("idle_ack_ignored", 32'(o_ack), 32'd0);
      end while (o_grant == '0 && w < 20);
      chk("grant", 32'(o_grant), 32'(oh));
      if (exp_wait > 0) chk("grant_latency", 32'(w), 32'(exp_wait));
      got = exp;
      if (exp >= 0) m_last = exp;
      for (int b = 1; b <= TO; b++) begin
         if (b > 1) begin
            @(posedge clk); #1;
         end
         i_mem_ack = (b == delay);
         i_mem_rdt = rdt;
         #1;
         chk("mem_cyc", 32'(o_mem_cyc), 32'd1);
         chk("mem_we",  32'(o_mem_we),  32'(m_we[exp]));
         chk("mem_adr", o_mem_adr, m_adr[exp]);
         chk("mem_dat", o_mem_dat, m_dat[exp]);
         chk("mem_sel", 32'(o_mem_sel), 32'(m_sel[exp]));
         if (b == delay || (delay == 0 && b == TO)) begin
            chk("ack", 32'(o_ack), 32'(oh));
            chk("rdt", o_rdt, (b == delay) ? rdt : 32'd0);
            if (delay == 0) m_err = 1'b1;
            break;
         end
         chk("ack_early", 32'(o_ack), 32'd0);
      end
      @(posedge clk); #1;
      i_mem_ack = 1'($urandom);
      i_cyc     = i_cyc & ~oh;
      if (rereq && exp >= 0) begin
         rand_core(exp);
         i_cyc = i_cyc | oh;
      end
      #1;
      chk("guard_ack",   32'(o_ack),     32'd0);
      chk("guard_cyc",   32'(o_mem_cyc), 32'd0);
      chk("guard_grant", 32'(o_grant),   32'd0);
      chk("err_flag",    32'(o_err),     32'(m_err));
      i_mem_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int k;
      int delay;
      int w;
      int rr_exp [6];
      rr_exp = '{0, 1, 2, 3, 0, 1};

      // Reset with random inputs
      rst       = 1'b0;
      i_cyc     = N'($urandom);
      i_we      = N'($urandom);
      i_adr     = {$urandom, $urandom, $urandom, $urandom};
      i_dat     = {$urandom, $urandom, $urandom, $urandom};
      i_sel     = 16'($urandom);
      i_mem_ack = 1'b1;
      i_mem_rdt = $urandom;
      m_last    = N - 1;
      m_err     = 1'b0;
      for (int c = 0; c < N; c++) rand_core(c);
      #22;
      chk("rst_mem_cyc", 32'(o_mem_cyc), 32'd0);
      chk("rst_grant",   32'(o_grant),   32'd0);
      chk("rst_ack",     32'(o_ack),     32'd0);
      chk("rst_err",     32'(o_err),     32'd0);
      chk("rst_rdt",     o_rdt,          32'd0);

      // Lone request from core 2 right after release
      i_cyc     = 4'b0100;
      i_mem_ack = 1'b0;
      @(negedge clk) rst = 1'b1;
      txn(1, $urandom, 1'b0, 1, got);
      chk("first_grant_core", 32'(got), 32'd2);

      // Single read by core 1
      set_core(1, 1'b0, 32'h40, $urandom, 4'hF);
      i_cyc = 4'b0010;
      txn(1, 32'hDEADBEEF, 1'b0, 2, got);
      chk("read_core", 32'(got), 32'd1);

      // Write forwarding from core 3
      set_core(3, 1'b1, 32'h10, 32'h12345678, 4'b0011);
      i_cyc = 4'b1000;
      txn(3, $urandom, 1'b0, 2, got);

      // Timeout on core 2, then core 0 served normally
      i_cyc = 4'b0100;
      txn(0, $urandom, 1'b0, 2, got);
      chk("timeout_err", 32'(o_err), 32'd1);
      i_cyc = 4'b0001;
      txn(2, $urandom, 1'b0, 2, got);
      chk("after_timeout_core", 32'(got), 32'd0);
      chk("err_sticky", 32'(o_err), 32'd1);

      // Reset in the middle of BUSY
      i_cyc = 4'b0010;
      w = 0;
      do begin
         @(posedge clk); #2;
         w++;
      end while (o_grant == '0 && w < 10);
      chk("rst_busy_grant", 32'(o_grant), 32'h2);
      #3;
      rst       = 1'b0;
      i_mem_ack = 1'b1;
      #1;
      chk("rst_busy_cyc",   32'(o_mem_cyc), 32'd0);
      chk("rst_busy_grant0", 32'(o_grant),  32'd0);
      chk("rst_busy_ack",   32'(o_ack),     32'd0);
      chk("rst_busy_err",   32'(o_err),     32'd0);
      m_last    = N - 1;
      m_err     = 1'b0;
      i_cyc     = '0;
      i_mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_ack", 32'(o_ack), 32'd0);

      // Round-robin with every core requesting continuously
      for (int c = 0; c < N; c++) rand_core(c);
      i_cyc = '1;
      for (int t = 0; t < 6; t++) begin
         txn($urandom_range(1, 4), $urandom, 1'b1, (t == 0) ? 0 : 2, got);
         chk("rr_order", 32'(got), 32'(rr_exp[t]));
      end

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, N - 1);
            if (((i_cyc >> k) & N'(1)) == '0) begin
               rand_core(k);
               i_cyc = i_cyc | (N'(1) << k);
            end
         end
         if (i_cyc == '0) begin
            k = $urandom_range(0, N - 1);
            rand_core(k);
            i_cyc = N'(1) << k;
         end
         delay = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
         txn(delay, $urandom, 1'($urandom), 2, got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dbus_arbiter.md
# dbus_arbiter

Round-robin Wishbone data-bus arbiter that shares the single `shared_memory` port between `NUM_CORES` SERV cores in `serv_gpu`. It takes one classic-cycle request from each core's dbus and forwards the granted core's address, write data, select and write-enable to memory. It routes the memory acknowledge back to that core only. A per-transaction timeout turns a missing memory ack into an error-ack, so a stalled slave cannot hang the barrier logic.

## Interface
- `NUM_CORES`, 4: number of requesting cores, 1..16.
- `TIMEOUT`, 16: maximum BUSY cycles before a forced ack, 2..255.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_cyc` in NUM_CORES: per-core dbus cycle request; held high until acked.
- `i_we` in NUM_CORES: per-core write enable.
- `i_adr` in NUM_CORES*32: per-core address; core k occupies bits [32k+31:32k].
- `i_dat` in NUM_CORES*32: per-core write data, same packing.
- `i_sel` in NUM_CORES*4: per-core byte selects, same packing with 4 bits per core.
- `o_ack` out NUM_CORES: per-core acknowledge, one-cycle pulse.
- `o_rdt` out 32: read data, broadcast to all cores; valid only with the matching `o_ack` bit.
- `o_mem_cyc` out 1: memory cycle.
- `o_mem_we` out 1: memory write enable.
- `o_mem_adr` out 32: memory address.
- `o_mem_dat` out 32: memory write data.
- `o_mem_sel` out 4: memory byte selects.
- `i_mem_ack` in 1: memory acknowledge.
- `i_mem_rdt` in 32: memory read data.
- `o_grant` out NUM_CORES: one-hot current owner; 0 when idle.
- `o_err` out 1: sticky flag, set on any timeout; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, GUARD.
- **IDLE**
  - If any `i_cyc` bit is set, select the first requester searching upward from `last+1`, wrapping modulo NUM_CORES.
  - Register its index into `owner`, set `last`=owner, clear the timeout counter, and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - `o_mem_cyc`=1.
  - `o_mem_we`, `o_mem_adr`, `o_mem_dat` and `o_mem_sel` are muxed combinationally from core `owner`.
  - `o_grant`=onehot(owner).
  - `o_ack[owner]` = `i_mem_ack`, or the timeout hit.
  - `o_rdt` = `i_mem_rdt` on a real ack; `o_rdt` = 0 on a timeout ack.
  - Exit to GUARD on the cycle a real ack or a timeout ack is issued.
  - Timeout hit means the counter equals TIMEOUT-1 with `i_mem_ack` low. The timeout ack is issued on that cycle and sets `o_err`.
  - Otherwise the counter increments every BUSY cycle.
- **GUARD**: one cycle with all outputs idle. It lets the acked core drop `i_cyc` before re-arbitration, so a stale request is never re-granted. Always go to IDLE.
- **Outputs outside BUSY**: `o_mem_cyc`=0, `o_grant`=0, `o_ack`=0. `o_mem_*` data/address/select outputs are driven from core `owner`; the memory ignores them because cyc is low.
- **Core drops `i_cyc` mid-BUSY** (protocol violation): the transaction still completes to memory. The ack is still pulsed.
- **Fairness**: `last` advances only on a grant. With all cores requesting continuously, the grant order is 0,1,…,N-1,0,…
- `NUM_CORES`=1 degenerates to pass-through plus the GUARD bubble.
- Memory ack arriving in IDLE or GUARD is ignored.
- **Reset values**: FSM state IDLE, `last`=NUM_CORES-1 (so core 0 wins first), `owner`=0, counter=0, `o_err`=0, `o_ack`=0, `o_grant`=0, `o_mem_cyc`=0, `o_rdt`=0.
- Reset asserted mid-BUSY aborts the transaction immediately. The core is not acked.

## Timing
- **Request-to-memory latency**: `i_cyc` seen at edge N in IDLE gives `o_mem_cyc` high in cycle N+1.
- **Ack path**: combinational from `i_mem_ack` to `o_ack`. No added latency.
- **Throughput**
  - With a 1-cycle-ack memory, a transaction spans IDLE, BUSY, GUARD: 3 cycles per transaction.
  - Back-to-back grants are 3 cycles apart.
- **Timeout ack**: occurs exactly TIMEOUT cycles after entering BUSY.
- **Combinational paths**: only the owner mux and the ack gating. The owner index, the counter and the FSM state are registers.

## Test plan
- **Reset**
  - Stimulus: assert `rst`=0 with random inputs.
  - Required: `o_mem_cyc`=0, `o_grant`=0, `o_ack`=0, `o_err`=0; after release, a lone `i_cyc`=4'b0100 is granted with `o_grant`=4'b0100 one cycle later.
- **Single read**
  - Stimulus: core 1 reads `adr`=0x40; memory acks in the first BUSY cycle with `rdt`=0xDEADBEEF.
  - Required: `o_ack`=4'b0010 for exactly one cycle and `o_rdt`=0xDEADBEEF; the next grant is not earlier than 2 cycles later.
- **Round-robin**
  - Stimulus: all 4 cores hold `i_cyc` and re-request after each ack.
  - Required: grant sequence 0,1,2,3,0,1; no core is granted twice before every other requester has been granted.
- **Write forwarding**
  - Stimulus: core 3 writes `adr`=0x10, `dat`=0x12345678, `sel`=4'b0011.
  - Required: `o_mem_we`=1 and `o_mem_*` carry exactly those values while `o_mem_cyc`=1.
- **Timeout**
  - Stimulus: TIMEOUT=16; memory never acks core 2.
  - Required: `o_ack[2]` pulses 16 cycles after BUSY entry with `o_rdt`=0; `o_err`=1 and stays set; the next requester is then served normally.
- **Reset mid-BUSY**
  - Stimulus: assert `rst` during BUSY.
  - Required: `o_mem_cyc` drops asynchronously and no `o_ack` pulse occurs.
